multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/opcode_classifier.sv | 24 ++
 rtl/multicycle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer:
// FSM state encodings, opcode classes, opcode constants and mux selects.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_BR      = 3'd1,
        CLS_J       = 3'd2,
        CLS_IMM     = 3'd3,
        CLS_LD      = 3'd4,
        CLS_ST      = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BCOND = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LB    = 6'd32;
    localparam logic [5:0] OP_LH    = 6'd33;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALU B-operand select
    localparam logic [1:0] ALUB_REG   = 2'd0;
    localparam logic [1:0] ALUB_FOUR  = 2'd1;
    localparam logic [1:0] ALUB_IMM   = 2'd2;
    localparam logic [1:0] ALUB_BROFF = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU  = 2'd0;
    localparam logic [1:0] PCSRC_BR   = 2'd1;
    localparam logic [1:0] PCSRC_JUMP = 2'd2;

    // Access size code for loads/stores: byte=01, half=10, word=11.
    // The low two opcode bits distinguish byte (00), half (01) and word (11).
    function automatic logic [1:0] mem_size(input logic [5:0] op);
        case (op[1:0])
            2'b00:   mem_size = 2'b01;
            2'b01:   mem_size = 2'b10;
            default: mem_size = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class decode.
module opcode_classifier
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [2:0] op_class_o
);

    // Map each opcode onto its class; anything unlisted is illegal.
    always_comb begin
        op_class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_RTYPE:                                 op_class_o = CLS_R;
            OP_BCOND, OP_BEQ, OP_BNE:                 op_class_o = CLS_BR;
            OP_J, OP_JAL:                             op_class_o = CLS_J;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
            OP_XORI:                                  op_class_o = CLS_IMM;
            OP_LB, OP_LH, OP_LW:                      op_class_o = CLS_LD;
            OP_SB, OP_SH, OP_SW:                      op_class_o = CLS_ST;
            default:                                  op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control sequencer.
// Optional build macro: MCS_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | instruction read in flight, PC+4 on completion
// DECODE | classify opcode, precompute branch target
// EXEC   | ALU operation, branch/jump resolution
// MEM    | load/store access in flight
// WB     | register file write-back
module multicycle_sequencer
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       run,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] MemRead,
    output logic [1:0] Memwrite,
    output logic [6:0] ALUOP,
    output logic [2:0] state,
    output logic       illegal
`ifdef MCS_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_e     state_q, state_d;
    op_class_e  class_q, class_d;
    logic [5:0] opcode_q, opcode_d;
    logic [2:0] live_class_raw;
    op_class_e  live_class;

    opcode_classifier u_classifier (
        .opcode_i   (opcode),
        .op_class_o (live_class_raw)
    );

    assign live_class = op_class_e'(live_class_raw);
    assign state      = state_q;

    // State, latched class and latched opcode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            class_q  <= CLS_R;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic; opcode and class are captured only in DECODE.
    always_comb begin
        state_d  = state_q;
        class_d  = class_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready)  state_d = ST_DECODE;
                else if (!run)  state_d = ST_IDLE;
            end
            ST_DECODE: begin
                class_d  = live_class;
                opcode_d = opcode;
                state_d  = (live_class == CLS_ILLEGAL) ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R, CLS_IMM:  state_d = ST_WB;
                    CLS_LD, CLS_ST:  state_d = ST_MEM;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) state_d = (class_q == CLS_LD) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the current state and latched class.
    // FETCH completion strobes and the DECODE illegal flag also look at the
    // live handshake/opcode because they must act in that same cycle.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        ALUSrcB  = ALUB_REG;
        PCSource = PCSRC_ALU;
        MemRead  = 2'b00;
        Memwrite = 2'b00;
        ALUOP    = 7'd0;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MemRead = 2'b11;
                if (mem_ready) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrcB  = ALUB_FOUR;
                    PCSource = PCSRC_ALU;
                end
            end
            ST_DECODE: begin
                ALUSrcB = ALUB_BROFF;
                illegal = (live_class == CLS_ILLEGAL);
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOP   = (class_q == CLS_R) ? 7'd0 : {1'b1, opcode_q};
                case (class_q)
                    CLS_IMM, CLS_LD, CLS_ST: ALUSrcB = ALUB_IMM;
                    default:                 ALUSrcB = ALUB_REG;
                endcase
                if (class_q == CLS_BR) begin
                    Branch   = 1'b1;
                    PCSource = PCSRC_BR;
                end
                if (class_q == CLS_J) begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                    RegWrite = (opcode_q == OP_JAL);
                end
            end
            ST_MEM: begin
                IorD = 1'b1;
                if (class_q == CLS_LD) MemRead  = mem_size(opcode_q);
                if (class_q == CLS_ST) Memwrite = mem_size(opcode_q);
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDst   = (class_q == CLS_R);
                MemtoReg = (class_q == CLS_LD);
            end
            default: ;
        endcase
    end

`ifdef MCS_RETIRE_CNT_EN
    logic [31:0] retired_q;
    logic        retire_evt;

    // An instruction retires whenever EXEC, MEM or WB hands back to FETCH/IDLE.
    assign retire_evt = (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) &&
                        (state_d == ST_FETCH || state_d == ST_IDLE);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          retired_q <= '0;
        else if (retire_evt) retired_q <= retired_q + 32'd1;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction is expanded
// into its expected per-cycle phase list from the opcode class, then played
// with randomized wait states, run and don't-care opcode values.
module tb_multicycle_sequencer;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5;
    localparam int C_R = 0, C_BR = 1, C_J = 2, C_IMM = 3, C_LD = 4, C_ST = 5, C_ILL = 6;

    typedef struct packed {
        logic       PCWrite;
        logic       IRWrite;
        logic       IorD;
        logic       RegWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       ALUSrcA;
        logic       Branch;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic [1:0] MemRead;
        logic [1:0] Memwrite;
        logic [6:0] ALUOP;
        logic       illegal;
    } ctl_t;

    typedef struct {
        int st;
        bit mr;
        bit rn;
    } step_t;

    logic       clk, rst_n, mem_ready, run;
    logic [5:0] opcode;
    logic       PCWrite, IRWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA, Branch, illegal;
    logic [1:0] ALUSrcB, PCSource, MemRead, Memwrite;
    logic [6:0] ALUOP;
    logic [2:0] state;
`ifdef MCS_RETIRE_CNT_EN
    logic [31:0] retired;
    logic [31:0] retire_model;
`endif

    int checks   = 0;
    int failures = 0;
    bit tb_idle  = 1;

    multicycle_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .run       (run),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .IorD      (IorD),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .ALUSrcA   (ALUSrcA),
        .Branch    (Branch),
        .ALUSrcB   (ALUSrcB),
        .PCSource  (PCSource),
        .MemRead   (MemRead),
        .Memwrite  (Memwrite),
        .ALUOP     (ALUOP),
        .state     (state),
        .illegal   (illegal)
`ifdef MCS_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cls_of(input logic [5:0] op);
        int v = int'(op);
        if (v == 0)                          return C_R;
        if (v inside {1, 4, 5})              return C_BR;
        if (v inside {2, 3})                 return C_J;
        if (v inside {8, 10, 12, 13, 14})    return C_IMM;
        if (v inside {32, 33, 35})           return C_LD;
        if (v inside {40, 41, 43})           return C_ST;
        return C_ILL;
    endfunction

    function automatic logic [1:0] size_of(input logic [5:0] op);
        int v = int'(op);
        if (v == 32 || v == 40) return 2'b01;
        if (v == 33 || v == 41) return 2'b10;
        return 2'b11;
    endfunction

    // Expected control word for one cycle of a phase.
    function automatic ctl_t exp_ctl(input int st, input int c, input logic [5:0] op, input bit mr);
        ctl_t e = '0;
        case (st)
            S_FETCH: begin
                e.MemRead = 2'b11;
                if (mr) begin
                    e.IRWrite = 1'b1;
                    e.PCWrite = 1'b1;
                    e.ALUSrcB = 2'd1;
                end
            end
            S_DECODE: begin
                e.ALUSrcB = 2'd3;
                e.illegal = (c == C_ILL);
            end
            S_EXEC: begin
                e.ALUSrcA = 1'b1;
                e.ALUSrcB = (c == C_IMM || c == C_LD || c == C_ST) ? 2'd2 : 2'd0;
                e.ALUOP   = (c == C_R) ? 7'd0 : {1'b1, op};
                if (c == C_BR) begin
                    e.Branch   = 1'b1;
                    e.PCSource = 2'd1;
                end
                if (c == C_J) begin
                    e.PCWrite  = 1'b1;
                    e.PCSource = 2'd2;
                    e.RegWrite = (op == 6'd3);
                end
            end
            S_MEM: begin
                e.IorD = 1'b1;
                if (c == C_LD) e.MemRead  = size_of(op);
                if (c == C_ST) e.Memwrite = size_of(op);
            end
            S_WB: begin
                e.RegWrite = 1'b1;
                e.RegDst   = (c == C_R);
                e.MemtoReg = (c == C_LD);
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t obs_ctl(input int st);
        ctl_t o;
        o = {PCWrite, IRWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA, Branch,
             ALUSrcB, PCSource, MemRead, Memwrite, ALUOP, illegal};
        if (st != S_EXEC) o.ALUOP = 7'd0;
        return o;
    endfunction

    function automatic step_t mk(input int st, input bit mr, input bit rn);
        step_t s;
        s.st = st;
        s.mr = mr;
        s.rn = rn;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Build the phase list of one instruction and play it cycle by cycle.
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                            input bit wb_run, input bit abort_mem);
        step_t q[$];
        int    c = cls_of(op);
        ctl_t  e;
        if (tb_idle) q.push_back(mk(S_IDLE, 1'($urandom_range(0, 1)), 1'b1));
        for (int i = 0; i < fw; i++) q.push_back(mk(S_FETCH, 1'b0, 1'b1));
        q.push_back(mk(S_FETCH, 1'b1, 1'($urandom_range(0, 1))));
        q.push_back(mk(S_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        if (c != C_ILL) begin
            q.push_back(mk(S_EXEC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            if (c == C_LD || c == C_ST) begin
                for (int i = 0; i < mw; i++) q.push_back(mk(S_MEM, 1'b0, 1'($urandom_range(0, 1))));
                q.push_back(mk(S_MEM, 1'b1, 1'($urandom_range(0, 1))));
            end
            if (c == C_R || c == C_IMM || c == C_LD)
                q.push_back(mk(S_WB, 1'($urandom_range(0, 1)), wb_run));
        end
        foreach (q[i]) begin
            @(negedge clk);
            opcode    = (q[i].st == S_DECODE) ? op : 6'($urandom_range(0, 63));
            mem_ready = q[i].mr;
            run       = q[i].rn;
            #1;
            e = exp_ctl(q[i].st, c, op, q[i].mr);
            chk($sformatf("state op=%0d step=%0d", op, i), 32'(state), 32'(q[i].st));
            chk($sformatf("ctl op=%0d step=%0d st=%0d", op, i, q[i].st), 32'(obs_ctl(q[i].st)), 32'(e));
            if (abort_mem && q[i].st == S_MEM) begin
                #1 rst_n = 1'b0;
                #1;
                chk("reset_mid_mem state", 32'(state), 32'(S_IDLE));
                chk("reset_mid_mem Memwrite", 32'(Memwrite), 32'd0);
                chk("reset_mid_mem ctl", 32'(obs_ctl(S_EXEC)), 32'd0);
                run = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    #1 chk("post_reset idle", 32'(state), 32'(S_IDLE));
                end
`ifdef MCS_RETIRE_CNT_EN
                retire_model = 32'd0;
`endif
                tb_idle = 1'b1;
                return;
            end
        end
        tb_idle = (q[q.size()-1].st == S_WB) && !wb_run;
`ifdef MCS_RETIRE_CNT_EN
        if (c != C_ILL) retire_model = retire_model + 32'd1;
`endif
    endtask

    // Stop in FETCH: run low with no completed fetch returns to IDLE.
    task automatic fetch_stop();
        if (tb_idle) return;
        @(negedge clk);
        opcode    = 6'($urandom_range(0, 63));
        mem_ready = 1'b0;
        run       = 1'b0;
        #1;
        chk("fetch_stop in_fetch", 32'(state), 32'(S_FETCH));
        chk("fetch_stop ctl", 32'(obs_ctl(S_FETCH)), 32'(exp_ctl(S_FETCH, C_R, 6'd0, 1'b0)));
        @(negedge clk);
        #1;
        chk("fetch_stop to_idle", 32'(state), 32'(S_IDLE));
        chk("fetch_stop idle ctl", 32'(obs_ctl(S_IDLE)), 32'd0);
        tb_idle = 1'b1;
    endtask

    logic [5:0] legal_ops[17] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12,
                                  6'd13, 6'd14, 6'd32, 6'd33, 6'd35, 6'd40, 6'd41, 6'd43};

    initial begin
        rst_n     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'd0;
`ifdef MCS_RETIRE_CNT_EN
        retire_model = 32'd0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("reset state", 32'(state), 32'(S_IDLE));
        chk("reset ctl", 32'(obs_ctl(S_EXEC)), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("idle waits for run", 32'(state), 32'(S_IDLE));
        tb_idle = 1'b1;

        do_instr(6'd0,  0, 0, 1'b1, 1'b0);   // R-type, 4 cycles
        do_instr(6'd35, 1, 3, 1'b1, 1'b0);   // LW, MEM held 4 cycles
        do_instr(6'd43, 0, 2, 1'b1, 1'b0);   // SW
        do_instr(6'd4,  0, 0, 1'b1, 1'b0);   // BEQ, 3 cycles
        do_instr(6'd3,  2, 0, 1'b1, 1'b0);   // JAL
        do_instr(6'd63, 0, 0, 1'b1, 1'b0);   // illegal
        do_instr(6'd12, 0, 0, 1'b0, 1'b0);   // ANDI then stop
        do_instr(6'd33, 0, 0, 1'b1, 1'b0);   // LH, zero-wait MEM
        fetch_stop();
        do_instr(6'd41, 0, 2, 1'b1, 1'b1);   // SH, reset mid-access

`ifdef MCS_RETIRE_CNT_EN
        do_instr(6'd0,  0, 0, 1'b1, 1'b0);
        do_instr(6'd32, 1, 1, 1'b1, 1'b0);
        do_instr(6'd63, 0, 0, 1'b1, 1'b0);
        do_instr(6'd40, 0, 0, 1'b1, 1'b0);
        do_instr(6'd5,  0, 0, 1'b1, 1'b0);
        do_instr(6'd2,  0, 0, 1'b1, 1'b0);
        @(negedge clk);
        run = 1'b0;
        mem_ready = 1'b0;
        #1 chk("retired after 5", retired, 32'd5);
        fetch_stop();
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        #1 chk("retired preload", retired, 32'hFFFF_FFFF);
        retire_model = 32'hFFFF_FFFF;
        do_instr(6'd1, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        #1 chk("retired wrap", retired, 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal_ops[$urandom_range(0, 16)];
            if ($urandom_range(0, 7) == 0) fetch_stop();
            do_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) != 0, 1'b0);
        end

`ifdef MCS_RETIRE_CNT_EN
        @(negedge clk);
        #1 chk("retired random", retired, retire_model);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
